// File: rtl/tama_pkg.sv
// tama_pkg: shared constants and types for the tamagotchi host link.
package tama_pkg;
    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam int FRAME_BYTES = 6;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    typedef logic [2:0] byte_idx_t;
    function automatic logic [7:0] frame_checksum(input logic [31:0] payload);
        return payload[31:24] ^ payload[23:16] ^ payload[15:8] ^ payload[7:0];
    endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser, LSB first; ready on the last stop cycle allows gapless bytes.
module uart_tx_byte
    import tama_pkg::*;
#(
    parameter logic [15:0] CLKS_PER_BIT = 16'd1042
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);
    uart_state_t state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        tx_nxt, wrap;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
        end
    end
    always_comb begin
        wrap      = cnt == CLKS_PER_BIT - 16'd1;
        ready     = state == IDLE || (state == STOP && wrap);
        state_nxt = state;
        cnt_nxt   = (state == IDLE || wrap) ? '0 : cnt + 16'd1;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        case (state)
            IDLE:  if (valid) begin
                       state_nxt = START;
                       shift_nxt = data;
                   end
            START: if (wrap) begin
                       state_nxt = DATA;
                       bit_nxt   = '0;
                   end
            DATA:  if (wrap) begin
                       shift_nxt = shift >> 1;
                       bit_nxt   = bit_idx + 3'd1;
                       state_nxt = bit_idx == 3'd7 ? STOP : DATA;
                   end
            STOP:  if (wrap) begin
                       state_nxt = valid ? START : IDLE;
                       shift_nxt = valid ? data : shift;
                   end
            default: state_nxt = IDLE;
        endcase
        // tx is registered from the next state so the line never glitches
        tx_nxt = state_nxt == START ? 1'b0 : state_nxt == DATA ? shift_nxt[0] : 1'b1;
    end
endmodule

// File: rtl/stats_uart_tx.sv
// stats_uart_tx: snapshots the pet stats on request and sends them as a 6-byte 8N1 frame.
module stats_uart_tx
    import tama_pkg::*;
#(
    parameter logic [15:0] CLKS_PER_BIT = 16'd1042,
    parameter logic [7:0]  HEADER       = HEADER_BYTE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [3:0] hunger,
    input  logic [3:0] happiness,
    input  logic [3:0] health,
    input  logic [3:0] hygiene,
    input  logic [3:0] energy,
    input  logic [3:0] social,
    input  logic [7:0] status,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    logic [31:0] snap;
    byte_idx_t   idx;
    logic        pending, ready, valid, last, byte_end, new_frame;
    logic [7:0]  data;
    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx)
    );
    // data always presents the byte that follows the one in flight; byte 0 is the constant header
    always_comb begin
        last      = idx == byte_idx_t'(FRAME_BYTES - 1);
        byte_end  = busy && ready;
        valid     = busy ? (!last || pending || req) : req;
        new_frame = valid && ready && (!busy || last);
        data      = (!busy || last) ? HEADER :
                    idx == 3'd0     ? snap[31:24] :
                    idx == 3'd1     ? snap[23:16] :
                    idx == 3'd2     ? snap[15:8] :
                    idx == 3'd3     ? snap[7:0] : frame_checksum(snap);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            pending <= 1'b0;
            idx     <= '0;
            snap    <= '0;
        end else begin
            done <= byte_end && last;
            if (new_frame) begin
                busy    <= 1'b1;
                idx     <= '0;
                pending <= 1'b0;
                snap    <= {hunger, happiness, health, hygiene, energy, social, status};
            end else begin
                if (byte_end) begin
                    busy <= !last;
                    idx  <= last ? '0 : idx + 3'd1;
                end
                if (busy && req) pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stats_uart_tx.sv
// tb_stats_uart_tx: random and directed frames decoded off tx and compared with frames built from the stats.
module tb_stats_uart_tx;
    localparam int CPB = 4;
    logic clk = 1'b0, rst_n = 1'b0, req = 1'b0;
    logic [3:0] hunger = '0, happiness = '0, health = '0, hygiene = '0, energy = '0, social = '0;
    logic [7:0] status = '0;
    logic tx, busy, done;
    int n_checks = 0, n_errors = 0;
    int busy_cnt = 0, done_cnt = 0, rst_events = 0;
    int rx_base = 0, exp_base = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    stats_uart_tx #(.CLKS_PER_BIT(16'(CPB)), .HEADER(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .hunger    (hunger),
        .happiness (happiness),
        .health    (health),
        .hygiene   (hygiene),
        .energy    (energy),
        .social    (social),
        .status    (status),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    always @(negedge rst_n) rst_events++;

    // line receiver: finds a start bit, samples each bit mid-cell, drops bytes cut by a reset
    initial begin
        logic [7:0] b;
        logic sb, sp;
        int r0;
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                r0 = rst_events;
                repeat (CPB / 2) begin @(posedge clk); #1; end
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(posedge clk); #1; end
                    b[i] = tx;
                end
                repeat (CPB) begin @(posedge clk); #1; end
                sp = tx;
                if (r0 == rst_events) begin
                    check("start_bit", 32'(sb), 0);
                    check("stop_bit", 32'(sp), 1);
                    rx_q.push_back(b);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic set_stats(input logic [31:0] r);
        {hunger, happiness, health, hygiene, energy, social, status} = r;
    endtask

    task automatic push_exp(input int n);
        logic [7:0] f[6];
        f[0] = 8'hA5;
        f[1] = {hunger, happiness};
        f[2] = {health, hygiene};
        f[3] = {energy, social};
        f[4] = status;
        f[5] = f[1] ^ f[2] ^ f[3] ^ f[4];
        for (int i = 0; i < n; i++) exp_q.push_back(f[i]);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req;
        @(negedge clk) req = 1'b1;
        @(negedge clk) req = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int t = 0;
        while (busy === 1'b1 && t < bound) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", 32'(busy), 0);
        wait_neg(5);
    endtask

    task automatic check_rx(input string tag);
        int nr = rx_q.size() - rx_base;
        int ne = exp_q.size() - exp_base;
        check({tag, "_nbytes"}, nr, ne);
        for (int i = 0; i < nr && i < ne; i++) check(tag, 32'(rx_q[rx_base + i]), 32'(exp_q[exp_base + i]));
        rx_base = rx_q.size();
        exp_base = exp_q.size();
    endtask

    initial begin
        int bad, b0, d0;
        int hdr[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic wave[40];
        wait_neg(3);
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        // basic frame with header waveform, duration and single done
        set_stats(32'h37F0_9121);
        push_exp(6);
        b0 = busy_cnt; d0 = done_cnt;
        pulse_req;
        for (int i = 0; i < 40; i++) begin
            wave[i] = tx;
            @(negedge clk);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) if (wave[i] !== hdr[i / CPB][0]) bad++;
        check("hdr_wave", bad, 0);
        wait_idle(2000);
        check("basic_busy", busy_cnt - b0, 60 * CPB);
        check("basic_done", done_cnt - d0, 1);
        check_rx("basic");

        // inputs cleared right after acceptance must not reach the frame
        push_exp(6);
        pulse_req;
        set_stats(32'h0);
        wait_idle(2000);
        check_rx("isolate");

        for (int k = 0; k < 6; k++) begin
            set_stats($urandom());
            push_exp(6);
            wait_neg($urandom_range(0, 20));
            b0 = busy_cnt; d0 = done_cnt;
            pulse_req;
            wait_neg($urandom_range(0, 100));
            set_stats($urandom());
            wait_idle(2000);
            check("rand_busy", busy_cnt - b0, 60 * CPB);
            check("rand_done", done_cnt - d0, 1);
            check_rx("rand");
        end

        // second request pends, third is dropped; second frame uses late values
        set_stats($urandom());
        push_exp(6);
        b0 = busy_cnt; d0 = done_cnt;
        pulse_req;
        wait_neg(18);
        pulse_req;
        set_stats($urandom());
        push_exp(6);
        wait_neg(78);
        pulse_req;
        wait_idle(4000);
        check("pend_busy", busy_cnt - b0, 120 * CPB);
        check("pend_done", done_cnt - d0, 2);
        check_rx("pend");

        // request sampled on the very edge that ends the frame
        set_stats($urandom());
        push_exp(6);
        b0 = busy_cnt; d0 = done_cnt;
        pulse_req;
        wait_neg(199);
        set_stats($urandom());
        push_exp(6);
        wait_neg(39);
        pulse_req;
        wait_idle(4000);
        check("edge_busy", busy_cnt - b0, 120 * CPB);
        check("edge_done", done_cnt - d0, 2);
        check_rx("edge");

        // req held high for 300 cycles gives three frames
        set_stats($urandom());
        push_exp(6); push_exp(6); push_exp(6);
        b0 = busy_cnt; d0 = done_cnt;
        @(negedge clk) req = 1'b1;
        wait_neg(300);
        req = 1'b0;
        wait_idle(4000);
        check("held_busy", busy_cnt - b0, 180 * CPB);
        check("held_done", done_cnt - d0, 3);
        check_rx("held");

        // reset during byte 2, data bit 3
        set_stats($urandom());
        push_exp(2);
        d0 = done_cnt;
        pulse_req;
        wait_neg(97);
        rst_n = 1'b0;
        #1;
        check("arst_tx", 32'(tx), 1);
        check("arst_busy", 32'(busy), 0);
        wait_neg(3);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("arst_quiet", bad, 0);
        check("arst_done", done_cnt - d0, 0);
        check_rx("arst");

        set_stats($urandom());
        push_exp(6);
        pulse_req;
        wait_idle(2000);
        check_rx("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
